// File: rtl/dm_pkg.sv
// Shared debug-transport types: DTM opcodes, DTM error codes, the DTMCS
// layout and the DMI request/response records exchanged with the CDC.
package dm_pkg;

  typedef enum logic [1:0] {
    DTM_NOP   = 2'h0,
    DTM_READ  = 2'h1,
    DTM_WRITE = 2'h2
  } dtm_op_e;

  // DTM error codes as seen in dtmcs.dmistat and the captured DMI op field.
  localparam logic [1:0] DTM_SUCCESS = 2'h0;
  localparam logic [1:0] DTM_ERR     = 2'h2;
  localparam logic [1:0] DTM_BUSY    = 2'h3;

  localparam int unsigned DtmcsDmiResetBit     = 32'd16;
  localparam int unsigned DtmcsDmiHardResetBit = 32'd17;

  typedef struct packed {
    logic [13:0] zero1;
    logic        dmihardreset;
    logic        dmireset;
    logic        zero0;
    logic [2:0]  idle;
    logic [1:0]  dmistat;
    logic [5:0]  abits;
    logic [3:0]  version;
  } dtmcs_t;

  // The address field is sized for the default 7-bit DMI address.
  typedef struct packed {
    logic [6:0]  addr;
    dtm_op_e     op;
    logic [31:0] data;
  } dmi_req_t;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } dmi_resp_t;

  // Value loaded into the DTMCS scan register on Capture-DR.
  function automatic dtmcs_t dtmcs_capture(input logic [2:0] idle,
                                           input logic [1:0] stat,
                                           input logic [5:0] abits);
    dtmcs_t v;
    v         = dtmcs_t'(32'h0000_0000);
    v.idle    = idle;
    v.dmistat = stat;
    v.abits   = abits;
    v.version = 4'd1;
    return v;
  endfunction

endpackage

// File: rtl/dmi_jtag_dr.sv
// JTAG data-register stage of the debug transport module: DTMCS and DMI scan
// registers in the TCK domain, the DMI request/response FSM and the sticky
// DMI error status.
module dmi_jtag_dr
  import dm_pkg::*;
#(
  parameter int unsigned AbitsWidth = 32'd7,
  parameter logic [2:0]  IdleCycles = 3'd1
) (
  input  logic                  tck_i,
  input  logic                  trst_ni,
  input  logic                  dmi_clear_i,
  input  logic                  capture_i,
  input  logic                  shift_i,
  input  logic                  update_i,
  input  logic                  tdi_i,
  input  logic                  dtmcs_select_i,
  output logic                  dtmcs_tdo_o,
  input  logic                  dmi_select_i,
  output logic                  dmi_tdo_o,
  output logic                  dmi_req_valid_o,
  input  logic                  dmi_req_ready_i,
  output logic [AbitsWidth-1:0] dmi_req_addr_o,
  output logic [31:0]           dmi_req_data_o,
  output logic [1:0]            dmi_req_op_o,
  input  logic                  dmi_resp_valid_i,
  output logic                  dmi_resp_ready_o,
  input  logic [31:0]           dmi_resp_data_i,
  input  logic [1:0]            dmi_resp_i,
  output logic                  dmi_hardreset_o
);

  localparam int unsigned DmiWidth = AbitsWidth + 32'd34;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_READ       = 3'd1,
    ST_WAIT_READ  = 3'd2,
    ST_WRITE      = 3'd3,
    ST_WAIT_WRITE = 3'd4
  } state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [1:0]            r_error;
  logic [1:0]            w_error_next;
  logic [AbitsWidth-1:0] r_addr;
  logic [AbitsWidth-1:0] w_addr_next;
  logic [31:0]           r_data;
  logic [31:0]           w_data_next;
  logic [31:0]           r_dtmcs_sr;
  logic [31:0]           w_dtmcs_sr_next;
  logic [DmiWidth-1:0]   r_dmi_sr;
  logic [DmiWidth-1:0]   w_dmi_sr_next;
  logic                  r_req_valid;
  logic                  w_req_valid_next;
  logic [1:0]            r_req_op;
  logic [1:0]            w_req_op_next;
  logic                  r_hardreset;
  logic                  w_hardreset_next;
  logic                  w_dtmcs_update;
  logic                  w_dmireset;
  logic                  w_dmihardreset;
  logic                  w_dmi_capture;
  logic                  w_dmi_update;
  logic                  w_busy;
  dtmcs_t                w_dtmcs_capture;

  // DTMCS scan register next value and decode of the dmireset/dmihardreset writes
  always_comb begin
    w_dtmcs_capture = dtmcs_capture(IdleCycles, r_error, 6'(AbitsWidth));
    w_dtmcs_sr_next = r_dtmcs_sr;
    if (dtmcs_select_i && capture_i) begin
      w_dtmcs_sr_next = w_dtmcs_capture;
    end else if (dtmcs_select_i && shift_i) begin
      w_dtmcs_sr_next = {tdi_i, r_dtmcs_sr[31:1]};
    end else begin
      w_dtmcs_sr_next = r_dtmcs_sr;
    end
    w_dtmcs_update = dtmcs_select_i & update_i;
    w_dmireset     = w_dtmcs_update & r_dtmcs_sr[DtmcsDmiResetBit];
    w_dmihardreset = w_dtmcs_update & r_dtmcs_sr[DtmcsDmiHardResetBit];
  end

  // DMI scan register, request FSM and sticky error next state, then the
  // clear/hardreset/dmireset overrides in falling priority
  always_comb begin
    w_state_next  = r_state;
    w_error_next  = r_error;
    w_addr_next   = r_addr;
    w_data_next   = r_data;
    w_dmi_sr_next = r_dmi_sr;
    w_busy        = (r_state != ST_IDLE);
    w_dmi_capture = dmi_select_i & capture_i;
    w_dmi_update  = dmi_select_i & update_i;

    // A capture during an outstanding transaction reports busy in the op field.
    if (w_dmi_capture) begin
      if (w_busy) begin
        w_dmi_sr_next = {r_addr, r_data, DTM_BUSY};
      end else begin
        w_dmi_sr_next = {r_addr, r_data, r_error};
      end
    end else if (dmi_select_i && shift_i) begin
      w_dmi_sr_next = {tdi_i, r_dmi_sr[DmiWidth-1:1]};
    end else begin
      w_dmi_sr_next = r_dmi_sr;
    end

    case (r_state)
      ST_IDLE: begin
        if (w_dmi_update && (r_error == DTM_SUCCESS)) begin
          w_addr_next = r_dmi_sr[DmiWidth-1:34];
          w_data_next = r_dmi_sr[33:2];
          case (r_dmi_sr[1:0])
            DTM_READ:  w_state_next = ST_READ;
            DTM_WRITE: w_state_next = ST_WRITE;
            default:   w_state_next = ST_IDLE;
          endcase
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_READ: begin
        if (dmi_req_ready_i) begin
          w_state_next = ST_WAIT_READ;
        end else begin
          w_state_next = ST_READ;
        end
      end
      ST_WRITE: begin
        if (dmi_req_ready_i) begin
          w_state_next = ST_WAIT_WRITE;
        end else begin
          w_state_next = ST_WRITE;
        end
      end
      ST_WAIT_READ: begin
        if (dmi_resp_valid_i) begin
          w_state_next = ST_IDLE;
          w_data_next  = dmi_resp_data_i;
          if ((dmi_resp_i != DTM_SUCCESS) && (r_error == DTM_SUCCESS)) begin
            w_error_next = DTM_ERR;
          end else begin
            w_error_next = r_error;
          end
        end else begin
          w_state_next = ST_WAIT_READ;
        end
      end
      ST_WAIT_WRITE: begin
        if (dmi_resp_valid_i) begin
          w_state_next = ST_IDLE;
          if ((dmi_resp_i != DTM_SUCCESS) && (r_error == DTM_SUCCESS)) begin
            w_error_next = DTM_ERR;
          end else begin
            w_error_next = r_error;
          end
        end else begin
          w_state_next = ST_WAIT_WRITE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase

    // Any DMI capture or update while busy records busy, unless an error is already held.
    if (w_busy && (w_dmi_capture || w_dmi_update) && (w_error_next == DTM_SUCCESS)) begin
      w_error_next = DTM_BUSY;
    end else begin
      w_error_next = w_error_next;
    end

    if (dmi_clear_i) begin
      w_state_next = ST_IDLE;
      w_error_next = DTM_SUCCESS;
      w_addr_next  = '0;
      w_data_next  = 32'h0000_0000;
    end else if (w_dmihardreset) begin
      w_state_next = ST_IDLE;
      w_error_next = DTM_SUCCESS;
    end else if (w_dmireset) begin
      w_error_next = DTM_SUCCESS;
    end else begin
      w_state_next = w_state_next;
    end

    w_req_valid_next = (w_state_next == ST_READ) || (w_state_next == ST_WRITE);
    case (w_state_next)
      ST_READ:  w_req_op_next = DTM_READ;
      ST_WRITE: w_req_op_next = DTM_WRITE;
      default:  w_req_op_next = DTM_NOP;
    endcase
    w_hardreset_next = w_dmihardreset & ~dmi_clear_i;
  end

  // State, status, scan and registered request-output flops
  always_ff @(posedge tck_i or negedge trst_ni) begin
    if (!trst_ni) begin
      r_state     <= ST_IDLE;
      r_error     <= DTM_SUCCESS;
      r_addr      <= '0;
      r_data      <= 32'h0000_0000;
      r_dtmcs_sr  <= 32'h0000_0000;
      r_dmi_sr    <= '0;
      r_req_valid <= 1'b0;
      r_req_op    <= 2'd0;
      r_hardreset <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_error     <= w_error_next;
      r_addr      <= w_addr_next;
      r_data      <= w_data_next;
      r_dtmcs_sr  <= w_dtmcs_sr_next;
      r_dmi_sr    <= w_dmi_sr_next;
      r_req_valid <= w_req_valid_next;
      r_req_op    <= w_req_op_next;
      r_hardreset <= w_hardreset_next;
    end
  end

  assign dtmcs_tdo_o      = r_dtmcs_sr[0];
  assign dmi_tdo_o        = r_dmi_sr[0];
  assign dmi_req_valid_o  = r_req_valid;
  assign dmi_req_op_o     = r_req_op;
  assign dmi_req_addr_o   = r_addr;
  assign dmi_req_data_o   = r_data;
  assign dmi_resp_ready_o = (r_state == ST_WAIT_READ) || (r_state == ST_WAIT_WRITE);
  assign dmi_hardreset_o  = r_hardreset;

endmodule

// File: tb/tb_dmi_jtag_dr.sv
// Self-checking bench for dmi_jtag_dr: directed vector table, hand-written
// corner sequences and a randomized run against a transaction-level model.
module tb_dmi_jtag_dr;

  localparam int AW = 7;
  localparam int DW = AW + 34;

  logic          tck;
  logic          trst_n;
  logic          dmi_clear;
  logic          capture;
  logic          shift;
  logic          update;
  logic          tdi;
  logic          dtmcs_sel;
  logic          dtmcs_tdo;
  logic          dmi_sel;
  logic          dmi_tdo;
  logic          req_valid;
  logic          req_ready;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_data;
  logic [1:0]    req_op;
  logic          resp_valid;
  logic          resp_ready;
  logic [31:0]   resp_data;
  logic [1:0]    resp_code;
  logic          hardreset;

  dmi_jtag_dr #(.AbitsWidth(AW), .IdleCycles(3'd1)) dut (
    .tck_i            (tck),
    .trst_ni          (trst_n),
    .dmi_clear_i      (dmi_clear),
    .capture_i        (capture),
    .shift_i          (shift),
    .update_i         (update),
    .tdi_i            (tdi),
    .dtmcs_select_i   (dtmcs_sel),
    .dtmcs_tdo_o      (dtmcs_tdo),
    .dmi_select_i     (dmi_sel),
    .dmi_tdo_o        (dmi_tdo),
    .dmi_req_valid_o  (req_valid),
    .dmi_req_ready_i  (req_ready),
    .dmi_req_addr_o   (req_addr),
    .dmi_req_data_o   (req_data),
    .dmi_req_op_o     (req_op),
    .dmi_resp_valid_i (resp_valid),
    .dmi_resp_ready_o (resp_ready),
    .dmi_resp_data_i  (resp_data),
    .dmi_resp_i       (resp_code),
    .dmi_hardreset_o  (hardreset)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  initial tck = 1'b0;
  always #5 tck = ~tck;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [1:0]  op;
    logic [6:0]  addr;
    logic [31:0] wdata;
    logic [1:0]  rcode;
    logic [31:0] rdata;
    bit          exp_issue;
    logic [40:0] exp_cap;
    logic [1:0]  exp_stat;
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge tck);
    @(negedge tck);
  endtask

  // DTMCS value as defined by the register layout: idle=1, abits=7, version=1.
  function automatic logic [31:0] dtmcs_exp(input logic [1:0] stat);
    return {14'd0, 1'b0, 1'b0, 1'b0, 3'd1, stat, 6'd7, 4'd1};
  endfunction

  // Capture, shift len bits (LSB first) and optionally update; called at a negedge.
  task automatic scan(input bit sel_dmi, input logic [63:0] wval, input int len,
                      input bit do_upd, output logic [63:0] rval);
    rval      = 64'd0;
    dtmcs_sel = !sel_dmi;
    dmi_sel   = sel_dmi;
    capture   = 1'b1;
    tick();
    capture = 1'b0;
    shift   = 1'b1;
    for (int i = 0; i < len; i++) begin
      rval[i] = sel_dmi ? dmi_tdo : dtmcs_tdo;
      tdi     = wval[i];
      tick();
    end
    shift = 1'b0;
    tdi   = 1'b0;
    if (do_upd) begin
      update = 1'b1;
      tick();
      update = 1'b0;
    end
    dtmcs_sel = 1'b0;
    dmi_sel   = 1'b0;
  endtask

  task automatic dtmcs_rw(input string name, input logic [31:0] wval, input logic [1:0] exp_stat);
    logic [63:0] r;
    scan(1'b0, {32'd0, wval}, 32, 1'b1, r);
    check(name, r, {32'd0, dtmcs_exp(exp_stat)});
  endtask

  task automatic dmi_write(input logic [6:0] a, input logic [31:0] d, input logic [1:0] op);
    logic [63:0] r;
    scan(1'b1, {23'd0, a, d, op}, DW, 1'b1, r);
  endtask

  task automatic dmi_peek(input string name, input logic [6:0] a, input logic [31:0] d,
                          input logic [1:0] op);
    logic [63:0] r;
    scan(1'b1, 64'd0, DW, 1'b0, r);
    check(name, r, {23'd0, a, d, op});
  endtask

  task automatic check_req(input string name, input logic [1:0] op, input logic [6:0] a,
                           input logic [31:0] d);
    check({name, "_valid"}, {63'd0, req_valid}, 64'd1);
    check({name, "_op"},    {62'd0, req_op}, {62'd0, op});
    check({name, "_addr"},  {57'd0, req_addr}, {57'd0, a});
    check({name, "_data"},  {32'd0, req_data}, {32'd0, d});
  endtask

  task automatic handshake(input logic [1:0] op, input logic [6:0] a, input logic [31:0] d,
                           input int rdy_dly, input int rsp_dly,
                           input logic [31:0] rdata, input logic [1:0] rcode);
    for (int i = 0; i < rdy_dly; i++) begin
      tick();
      check_req("req_hold", op, a, d);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("valid_after_ready", {63'd0, req_valid}, 64'd0);
    check("resp_ready_wait", {63'd0, resp_ready}, 64'd1);
    for (int i = 0; i < rsp_dly; i++) begin
      tick();
    end
    resp_valid = 1'b1;
    resp_data  = rdata;
    resp_code  = rcode;
    tick();
    resp_valid = 1'b0;
    resp_code  = 2'd0;
    check("resp_ready_idle", {63'd0, resp_ready}, 64'd0);
  endtask

  initial begin
    logic [6:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_err;
    logic [1:0]  op;
    logic [6:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
    logic [1:0]  rc;
    bit          issued;
    bit          clr;

    vecs[0] = '{2'd1, 7'h10, 32'h0,          2'd0, 32'hDEADBEEF, 1'b1, {7'h10, 32'hDEADBEEF, 2'd0}, 2'd0};
    vecs[1] = '{2'd2, 7'h04, 32'h1,          2'd0, 32'h0,        1'b1, {7'h04, 32'h00000001, 2'd0}, 2'd0};
    vecs[2] = '{2'd0, 7'h7F, 32'h12345678,   2'd0, 32'h0,        1'b0, {7'h7F, 32'h12345678, 2'd0}, 2'd0};
    vecs[3] = '{2'd3, 7'h22, 32'hA5A5A5A5,   2'd0, 32'h0,        1'b0, {7'h22, 32'hA5A5A5A5, 2'd0}, 2'd0};
    vecs[4] = '{2'd1, 7'h33, 32'h0,          2'd2, 32'hCAFEF00D, 1'b1, {7'h33, 32'hCAFEF00D, 2'd2}, 2'd2};
    vecs[5] = '{2'd2, 7'h01, 32'hFFFFFFFF,   2'd0, 32'h0,        1'b0, {7'h33, 32'hCAFEF00D, 2'd2}, 2'd2};

    trst_n = 1'b0; dmi_clear = 1'b0; capture = 1'b0; shift = 1'b0; update = 1'b0;
    tdi = 1'b0; dtmcs_sel = 1'b0; dmi_sel = 1'b0; req_ready = 1'b0;
    resp_valid = 1'b0; resp_data = 32'd0; resp_code = 2'd0;
    repeat (3) @(negedge tck);
    trst_n = 1'b1;
    @(negedge tck);

    // Reset state
    check("rst_valid", {63'd0, req_valid}, 64'd0);
    check("rst_op", {62'd0, req_op}, 64'd0);
    check("rst_addr", {57'd0, req_addr}, 64'd0);
    check("rst_data", {32'd0, req_data}, 64'd0);
    check("rst_resp_ready", {63'd0, resp_ready}, 64'd0);
    check("rst_hardreset", {63'd0, hardreset}, 64'd0);
    check("rst_tdo", {62'd0, dtmcs_tdo, dmi_tdo}, 64'd0);
    dtmcs_rw("dtmcs_reset_read", 32'd0, 2'd0);
    check("dtmcs_raw_1071", {32'd0, dtmcs_exp(2'd0)}, 64'h1071);
    dmi_peek("dmi_reset_capture", 7'h0, 32'h0, 2'd0);

    // Directed vector table
    foreach (vecs[i]) begin
      dmi_write(vecs[i].addr, vecs[i].wdata, vecs[i].op);
      check("vec_issue", {63'd0, req_valid}, {63'd0, vecs[i].exp_issue});
      if (vecs[i].exp_issue) begin
        check_req("vec_req", vecs[i].op, vecs[i].addr, vecs[i].wdata);
        handshake(vecs[i].op, vecs[i].addr, vecs[i].wdata, 1, 1, vecs[i].rdata, vecs[i].rcode);
      end
      dmi_peek("vec_capture", vecs[i].exp_cap[40:34], vecs[i].exp_cap[33:2], vecs[i].exp_cap[1:0]);
      dtmcs_rw("vec_dmistat", 32'd0, vecs[i].exp_stat);
    end
    // Failed status is not overwritten by a later attempt; dmireset clears it.
    dmi_write(7'h05, 32'h5, 2'd1);
    check("failed_blocks_issue", {63'd0, req_valid}, 64'd0);
    dtmcs_rw("failed_sticky", 32'h0001_0000, 2'd2);
    dtmcs_rw("failed_cleared", 32'd0, 2'd0);

    // Write with ready held low, then busy scan while waiting for the response
    dmi_write(7'h04, 32'h1, 2'd2);
    for (int i = 0; i < 5; i++) begin
      tick();
      check_req("wr_stall", 2'd2, 7'h04, 32'h1);
    end
    req_ready = 1'b1;
    tick();
    req_ready = 1'b0;
    check("wr_wait_resp_ready", {63'd0, resp_ready}, 64'd1);
    check("wr_wait_valid", {63'd0, req_valid}, 64'd0);
    begin
      logic [63:0] r;
      scan(1'b1, {23'd0, 7'h11, 32'h0, 2'd1}, DW, 1'b1, r);
      check("busy_capture", r, {23'd0, 7'h04, 32'h1, 2'd3});
    end
    check("busy_update_ignored", {63'd0, req_valid}, 64'd0);
    dtmcs_rw("busy_dmistat", 32'd0, 2'd3);
    resp_valid = 1'b1; resp_code = 2'd0;
    tick();
    resp_valid = 1'b0;
    check("wr_done", {63'd0, resp_ready}, 64'd0);
    dtmcs_rw("busy_sticky_then_reset", 32'h0001_0000, 2'd3);
    dtmcs_rw("busy_cleared", 32'd0, 2'd0);
    dmi_write(7'h12, 32'h0, 2'd1);
    check_req("read_after_reset", 2'd1, 7'h12, 32'h0);
    handshake(2'd1, 7'h12, 32'h0, 0, 0, 32'h0BAD_F00D, 2'd0);

    // dmihardreset during an unaccepted read
    dmi_write(7'h05, 32'h0, 2'd1);
    check_req("hr_read", 2'd1, 7'h05, 32'h0);
    dtmcs_rw("hr_write", 32'h0002_0000, 2'd0);
    check("hr_pulse", {63'd0, hardreset}, 64'd1);
    check("hr_valid_drop", {63'd0, req_valid}, 64'd0);
    tick();
    check("hr_pulse_end", {63'd0, hardreset}, 64'd0);
    check("hr_idle", {63'd0, resp_ready}, 64'd0);
    dmi_peek("hr_capture_idle", 7'h05, 32'h0, 2'd0);

    // dmi_clear during an unaccepted write
    dmi_write(7'h09, 32'hA, 2'd2);
    check_req("clr_write", 2'd2, 7'h09, 32'hA);
    dmi_clear = 1'b1;
    tick();
    dmi_clear = 1'b0;
    check("clr_valid_drop", {63'd0, req_valid}, 64'd0);
    check("clr_no_pulse", {63'd0, hardreset}, 64'd0);
    check("clr_addr", {57'd0, req_addr}, 64'd0);
    dmi_peek("clr_capture", 7'h0, 32'h0, 2'd0);

    // Randomized transactions against a transaction-level model
    m_addr = 7'h0; m_data = 32'h0; m_err = 2'd0;
    for (int it = 0; it < 40; it++) begin
      op = 2'($urandom_range(0, 3));
      a  = 7'($urandom);
      d  = $urandom;
      dmi_write(a, d, op);
      issued = (m_err == 2'd0) && ((op == 2'd1) || (op == 2'd2));
      if (m_err == 2'd0) begin
        m_addr = a;
        m_data = d;
      end
      check("rnd_issue", {63'd0, req_valid}, {63'd0, issued});
      if (issued) begin
        check_req("rnd_req", op, m_addr, m_data);
        if ($urandom_range(0, 3) == 0) begin
          dmi_peek("rnd_busy_capture", m_addr, m_data, 2'd3);
          if (m_err == 2'd0) m_err = 2'd3;
        end
        rd = $urandom;
        rc = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        handshake(op, m_addr, m_data, $urandom_range(0, 3), $urandom_range(0, 3), rd, rc);
        if (op == 2'd1) m_data = rd;
        if ((rc != 2'd0) && (m_err == 2'd0)) m_err = 2'd2;
      end
      clr = ($urandom_range(0, 1) == 1);
      dtmcs_rw("rnd_dmistat", clr ? 32'h0001_0000 : 32'd0, m_err);
      if (clr) m_err = 2'd0;
      dmi_peek("rnd_capture", m_addr, m_data, m_err);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dmi_jtag_dr.md
# dmi_jtag_dr

JTAG data-register stage of the Debug Transport Module, downstream of the JTAG TAP controller. Owns the DTMCS (32-bit) and DMI (`AbitsWidth`+34-bit) scan registers in the TCK domain, clocked by the TAP's pass-through `tck`. Turns DMI scans into request/response transactions toward the DMI clock-domain crossing. Tracks the sticky DMI error status reported back through DTMCS.

## Interface
- `AbitsWidth`, default 7: DMI address width, 1..63; reported in `dtmcs.abits`.
- `IdleCycles`, default 3'd1: value reported in `dtmcs.idle`.

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- `tck_i`  in  1  JTAG clock, the only clock.
- `trst_ni`  in  1  asynchronous active-low reset.
- `dmi_clear_i`  in  1  TAP in Test-Logic-Reset; synchronous clear.
- `capture_i`  in  1  Capture-DR strobe from the TAP.
- `shift_i`  in  1  Shift-DR strobe from the TAP.
- `update_i`  in  1  Update-DR strobe from the TAP.
- `tdi_i`  in  1  serial data in.
- `dtmcs_select_i`  in  1  IR = DTMCSR.
- `dtmcs_tdo_o`  out  1  DTMCS shift register LSB.
- `dmi_select_i`  in  1  IR = DMIACCESS.
- `dmi_tdo_o`  out  1  DMI shift register LSB.
- `dmi_req_valid_o`  out  1  request valid.
- `dmi_req_ready_i`  in  1  request accepted.
- `dmi_req_addr_o`  out  `AbitsWidth`  request address.
- `dmi_req_data_o`  out  32  write data.
- `dmi_req_op_o`  out  2  request opcode: 1 = read, 2 = write.
- `dmi_resp_valid_i`  in  1  response valid.
- `dmi_resp_ready_o`  out  1  response accepted.
- `dmi_resp_data_i`  in  32  read data.
- `dmi_resp_i`  in  2  response code: 0 = ok, anything else = failed.
- `dmi_hardreset_o`  out  1  one-cycle pulse on a dtmcs.dmihardreset write.

## Operation

DTMCS capture value, MSB to LSB:
- 14'b0
- dmihardreset 0
- dmireset 0
- 1'b0
- idle = `IdleCycles`
- dmistat = `error_q`
- abits = `AbitsWidth`
- version = 4'd1

DTMCS scan:
- Load on `capture_i & dtmcs_select_i`.
- Shift on `shift_i & dtmcs_select_i`: shift right, `tdi_i` enters the MSB.
- Update on `update_i & dtmcs_select_i`:
  - bit16 (dmireset) clears `error_q`.
  - bit17 (dmihardreset) clears `error_q`, forces the FSM to Idle, deasserts the request, and pulses `dmi_hardreset_o`.

DMI register layout: `{addr, data[31:0], op[1:0]}`.
- Capture: load `{addr_q, data_q, error_q}`. If FSM ≠ Idle, first set `error_q` = 3 (busy, if 0) and capture op = 3.
- Shift: same rule as DTMCS.
- Update:
  - FSM ≠ Idle: set `error_q` = 3 if `error_q` = 0; no new request.
  - FSM Idle and `error_q` = 0: latch `addr_q` and `data_q` from the shift register, then act on op:
    - op 1 → Read.
    - op 2 → Write.
    - op 0/3 → no action.
  - `error_q` ≠ 0: update ignored.

`error_q` (2 bits) is sticky:
- Written only when it is 0.
- Cleared only by dmireset, dmihardreset, `dmi_clear_i` or reset.

FSM states: Idle, Read, WaitReadValid, Write, WaitWriteValid.
- Read/Write:
  - `dmi_req_valid_o` = 1, with op, `addr_q` and `data_q` on the request outputs.
  - On `dmi_req_ready_i` → WaitReadValid / WaitWriteValid.
- WaitRead/WaitWrite:
  - `dmi_resp_ready_o` = 1.
  - On `dmi_resp_valid_i` → Idle.
  - In WaitReadValid, `data_q` ← `dmi_resp_data_i`.
  - If `dmi_resp_i` ≠ 0 and `error_q` = 0, `error_q` ← 2 (failed).
- Request outputs are stable while valid and not ready.

`dmi_clear_i`:
- Clears the FSM to Idle, `error_q`, `addr_q` and `data_q`.
- Drops `dmi_req_valid_o` immediately; the downstream CDC flushes.
- `dmi_hardreset_o` is not pulsed.

## Timing
- Reset values:
  - All outputs 0, except `dmi_req_op_o` = 0.
  - FSM Idle; `error_q`, `addr_q`, `data_q` and both shift registers 0.
- TDO outputs come combinationally from shift register bit 0; the TAP retimes them on the falling edge.
- `dmi_req_valid_o` rises on the first `tck_i` edge after the Update-DR cycle, i.e. it is registered.
- Response accepted in the same cycle as valid: `dmi_resp_ready_o` is 1 combinationally in the Wait states.
- Simultaneous capture and busy: the capture value already shows op = 3.
- `dmi_hardreset_o` is one cycle wide.
- Priority order: reset > `dmi_clear_i` > dmihardreset > dmireset > FSM/update.

## Structure
- `dm_pkg` holds:
  - `dtm_op_e` (Nop=0, Read=1, Write=2)
  - the DTM error codes (ok=0, failed=2, busy=3)
  - the packed `dtmcs_t` struct
  - the `dmi_req_t`/`dmi_resp_t` structs
- State enum is local.
- No sub-module. DTMCS and DMI handling are two always blocks in one module.

## Test plan
- Reset, then DTMCS capture-shift 32 bits → reads 0x0000_1071 (`AbitsWidth` = 7, idle = 1).
- DMI scan addr = 0x10, data = 0, op = 1; downstream returns data 0xDEADBEEF with resp 0; rescan → captured data 0xDEADBEEF, op 0.
- DMI write addr = 0x04, data = 0x1, op = 2 with `dmi_req_ready_i` held low for 5 cycles → valid held, outputs stable; ready asserted → WaitWriteValid.
- New DMI scan while waiting for a response → captured op = 3, dmistat = 3, next update ignored; DTMCS write bit16 = 1 → dmistat reads 0 and a new read issues.
- Response with `dmi_resp_i` = 2 → dmistat = 2; a later busy does not overwrite it.
- dmihardreset (bit17) mid-Read → `dmi_hardreset_o` one-cycle pulse, `dmi_req_valid_o` drops next cycle, FSM Idle. `dmi_clear_i` mid-Write → same, but no pulse.
